// File: rtl/list_stat_collector.sv
// Splits a pointer stream into lists and queues one {head, tail, len, xsum, dup} record per list.
// A record is pushed on the gap edge and is visible one cycle later; input is never stalled, and records are dropped when the FIFO is full.
module list_stat_collector #(
    parameter int n     = 16,
    parameter int Width = $clog2(n),
    parameter int LenW  = Width + 1,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] in_ptr,
    input  logic             in_ptr_vld,
    output logic [Width-1:0] out_head,
    output logic [Width-1:0] out_tail,
    output logic [LenW-1:0]  out_len,
    output logic [Width-1:0] out_xsum,
    output logic             out_dup,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic             ovf,
    output logic [7:0]       drop_cnt
);

    localparam int AW = $clog2(Depth);

    typedef struct packed {
        logic [Width-1:0] head;
        logic [Width-1:0] tail;
        logic [LenW-1:0]  len;
        logic [Width-1:0] xsum;
        logic             dup;
    } rec_t;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t         state_q, state_d;
    rec_t           cur_q, cur_d;
    logic [n-1:0]   visited_q, visited_d;
    logic [n-1:0]   ptr_bit;
    logic           ev, start, accum, push;

    rec_t           mem_q [Depth];
    rec_t           last_q, head_rec;
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    cnt_q;
    logic           full, pop, do_wr, drop;
    logic           ovf_q;
    logic [7:0]     drop_cnt_q;

    // A valid-flagged null pointer counts as a gap.
    assign ev      = in_ptr_vld && (in_ptr != '0);
    assign ptr_bit = {{(n-1){1'b0}}, 1'b1} << in_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ev)  state_d = ACTIVE;
            ACTIVE:  if (!ev) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start = 1'b0;
        accum = 1'b0;
        push  = 1'b0;
        case (state_q)
            IDLE:    start = ev;
            ACTIVE: begin
                accum = ev;
                push  = !ev;
            end
            default: ;
        endcase
    end

    always_comb begin
        cur_d     = cur_q;
        visited_d = visited_q;
        if (start) begin
            cur_d.head = in_ptr;
            cur_d.tail = in_ptr;
            cur_d.len  = LenW'(1);
            cur_d.xsum = in_ptr;
            cur_d.dup  = 1'b0;
            visited_d  = ptr_bit;
        end else if (accum) begin
            cur_d.tail = in_ptr;
            cur_d.xsum = cur_q.xsum ^ in_ptr;
            cur_d.len  = (&cur_q.len) ? cur_q.len : cur_q.len + LenW'(1);
            if (visited_q[in_ptr]) cur_d.dup = 1'b1;
            visited_d  = visited_q | ptr_bit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q     <= '0;
            visited_q <= '0;
        end else begin
            cur_q     <= cur_d;
            visited_q <= visited_d;
        end
    end

    // A full FIFO still accepts a push when the head pops on the same edge.
    assign full  = (cnt_q == (AW+1)'(Depth));
    assign pop   = out_vld && out_rdy;
    assign do_wr = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= cur_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                last_q   <= mem_q[rd_ptr_q];
            end
            if (do_wr && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
            else if (!do_wr && pop) cnt_q <= cnt_q - (AW+1)'(1);
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    // When empty the outputs hold the last record handed out.
    assign out_vld  = (cnt_q != '0);
    assign head_rec = out_vld ? mem_q[rd_ptr_q] : last_q;
    assign out_head = head_rec.head;
    assign out_tail = head_rec.tail;
    assign out_len  = head_rec.len;
    assign out_xsum = head_rec.xsum;
    assign out_dup  = head_rec.dup;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_list_stat_collector.sv
// Directed bench for list_stat_collector: hand-computed records, overflow, simultaneous push/pop and async reset.
module tb_list_stat_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_ptr;
    logic       in_ptr_vld;
    logic [3:0] out_head, out_tail, out_xsum;
    logic [4:0] out_len;
    logic       out_dup, out_vld, out_rdy, ovf;
    logic [7:0] drop_cnt;

    int n_chk = 0;
    int n_err = 0;

    list_stat_collector #(.n(16), .Depth(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_ptr     (in_ptr),
        .in_ptr_vld (in_ptr_vld),
        .out_head   (out_head),
        .out_tail   (out_tail),
        .out_len    (out_len),
        .out_xsum   (out_xsum),
        .out_dup    (out_dup),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .ovf        (ovf),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rec(input string tag, input int h, input int t, input int l,
                           input int x, input int d);
        chk({tag, ".vld"},  32'(out_vld),  32'd1);
        chk({tag, ".head"}, 32'(out_head), 32'(h));
        chk({tag, ".tail"}, 32'(out_tail), 32'(t));
        chk({tag, ".len"},  32'(out_len),  32'(l));
        chk({tag, ".xsum"}, 32'(out_xsum), 32'(x));
        chk({tag, ".dup"},  32'(out_dup),  32'(d));
    endtask

    // Inputs change 1ns after an edge; the task returns 1ns after the edge that sampled them.
    task automatic drive(input int p, input logic v);
        in_ptr     = 4'(p);
        in_ptr_vld = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_ptr = '0; in_ptr_vld = 1'b0; out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.vld",  32'(out_vld),  32'd0);
        chk("rst.head", 32'(out_head), 32'd0);
        chk("rst.ovf",  32'(ovf),      32'd0);
        chk("rst.drop", 32'(drop_cnt), 32'd0);
        rst = 1'b0;

        // List 1,5,3,10 drained immediately.
        out_rdy = 1'b1;
        drive(1, 1); drive(5, 1); drive(3, 1); drive(10, 1);
        chk("l1.pending", 32'(out_vld), 32'd0);
        drive(0, 0);
        chk_rec("l1", 1, 10, 4, 13, 0);
        drive(0, 0);
        chk("l1.popped", 32'(out_vld), 32'd0);
        chk("l1.hold",   32'(out_head), 32'd1);

        // Two records held under backpressure; the second gap is a valid null pointer.
        out_rdy = 1'b0;
        drive(7, 1); drive(15, 1); drive(8, 1); drive(0, 0);
        chk_rec("l2a", 7, 8, 3, 0, 0);
        drive(6, 1); drive(0, 1);
        drive(0, 0); drive(0, 0);
        chk_rec("l2a.stable", 7, 8, 3, 0, 0);
        out_rdy = 1'b1;
        drive(0, 0);
        chk_rec("l2b", 6, 6, 1, 6, 0);
        drive(0, 0);
        chk("l2.empty", 32'(out_vld), 32'd0);

        // Duplicate detection, then a clean list confirms the bitmap cleared.
        drive(2, 1); drive(4, 1); drive(2, 1); drive(0, 0);
        chk_rec("dup", 2, 2, 3, 4, 1);
        drive(9, 1); drive(14, 1); drive(0, 0);
        chk_rec("nodup", 9, 14, 2, 7, 0);
        drive(0, 0);

        // Overflow: five single-pointer lists into a depth-4 FIFO.
        out_rdy = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(k, 1); drive(0, 0);
        end
        chk("ovf.before", 32'(ovf), 32'd0);
        drive(5, 1); drive(0, 0);
        chk("ovf.set",  32'(ovf),      32'd1);
        chk("ovf.drop", 32'(drop_cnt), 32'd1);
        out_rdy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("ovf.drain", 32'(out_head), 32'(k));
            drive(0, 0);
        end
        chk("ovf.empty", 32'(out_vld), 32'd0);

        // Push into a full FIFO coinciding with a pop.
        out_rdy = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(k, 1); drive(0, 0);
        end
        drive(6, 1);
        out_rdy = 1'b1;
        drive(0, 0);
        chk("pp.drop", 32'(drop_cnt), 32'd1);
        chk("pp.ovf",  32'(ovf),      32'd1);
        chk("pp.head", 32'(out_head), 32'd2);
        drive(0, 0); drive(0, 0); drive(0, 0);
        chk_rec("pp.last", 6, 6, 1, 6, 0);

        // Two records queued and a list in progress when reset hits.
        out_rdy = 1'b0;
        drive(7, 1); drive(0, 0);
        drive(9, 1); drive(14, 1);
        chk("pre.head", 32'(out_head), 32'd6);
        #2;
        rst = 1'b1; in_ptr = 4'd11; in_ptr_vld = 1'b1;
        #1;
        chk("arst.vld",  32'(out_vld),  32'd0);
        chk("arst.ovf",  32'(ovf),      32'd0);
        chk("arst.drop", 32'(drop_cnt), 32'd0);
        chk("arst.head", 32'(out_head), 32'd0);
        chk("arst.len",  32'(out_len),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(13, 1); drive(0, 0);
        chk_rec("post", 11, 13, 2, 6, 0);
        out_rdy = 1'b1;
        drive(0, 0);
        chk("post.single", 32'(out_vld), 32'd0);

        // 33-pointer loop saturates the 5-bit length.
        out_rdy = 1'b0;
        for (int i = 0; i < 33; i++) drive((i % 15) + 1, 1);
        drive(0, 0);
        chk_rec("sat", 1, 3, 31, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
